// File: rtl/updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_if
// Description : Control and status bundle for updown_counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             wrap;
    logic             ovf;

    modport master (
        output clr, load, load_val, en, up,
        input  count, at_max, at_min, wrap, ovf
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output count, at_max, at_min, wrap, ovf
    );
endinterface
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter
// Description : Up/down modulo counter with wrap/saturate, load, clear,
//               boundary flags and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    updown_counter_if.slave  bus
);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0] c_MAX = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] c_ONE = (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_step;
    logic [WIDTH-1:0] w_load_clamp;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;
    logic             w_next_ovf;
    logic             w_unused_msb;

    assign w_count_ext  = {1'b0, r_count};
    assign w_load_ext   = {1'b0, bus.load_val};
    assign w_step       = bus.up ? (w_count_ext + c_ONE) : (w_count_ext - c_ONE);
    // Step is only taken away from the boundary, so its top bit is never needed.
    assign w_unused_msb = w_step[WIDTH];
    assign w_load_clamp = (w_load_ext > c_MAX) ? c_MAX[WIDTH-1:0] : bus.load_val;

    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        w_next_ovf   = r_ovf;
        if (bus.clr) begin
            w_next_count = '0;
            w_next_ovf   = 1'b0;
        end else if (bus.load) begin
            w_next_count = w_load_clamp;
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_count_ext == c_MAX) begin
                    w_next_wrap  = 1'b1;
                    w_next_ovf   = 1'b1;
                    w_next_count = (SATURATE != 0) ? r_count : '0;
                end else begin
                    w_next_count = w_step[WIDTH-1:0];
                end
            end else begin
                if (w_count_ext == '0) begin
                    w_next_wrap  = 1'b1;
                    w_next_ovf   = 1'b1;
                    w_next_count = (SATURATE != 0) ? r_count : c_MAX[WIDTH-1:0];
                end else begin
                    w_next_count = w_step[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
            r_ovf   <= w_next_ovf;
        end
    end

    assign bus.count  = r_count;
    assign bus.at_max = (w_count_ext == c_MAX);
    assign bus.at_min = (r_count == '0);
    assign bus.wrap   = r_wrap;
    assign bus.ovf    = r_ovf;
endmodule
`default_nettype wire
